clkdiv_ctrl: RTL and testbench
==============================

Name: clkdiv_ctrl

Overview:
Run controller for the team's clock-divider timebase. It holds a programmable divide ratio and drives the divider's enable. It produces a one-cycle tick pulse every (div+1) clk cycles. Modes are continuous run or a burst of N ticks that ends with a done pulse. Configuration uses a valid/ready handshake and is accepted only while the block is idle.

Parameters:
DIV_W, 8, width of divide-ratio register; tick period = cfg_div+1 cycles
CNT_W, 16, width of burst length and tick counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration can be accepted (high only in IDLE)
cfg_div  input  DIV_W  divide ratio; tick period = cfg_div+1
cfg_burst  input  1  0 = continuous run, 1 = burst of cfg_count ticks
cfg_count  input  CNT_W  burst length in ticks
start  input  1  start request (level-sampled, acted on in IDLE only)
stop  input  1  abort request (acted on in RUN/BURST)
ena_out  output  1  enable to the divider datapath; high while running
tick  output  1  one-cycle pulse at end of each prescale period
busy  output  1  high in RUN, BURST or DONE
done  output  1  one-cycle pulse when a burst completes
tick_cnt  output  CNT_W  ticks issued since last start; wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst=1): state=IDLE, div_reg=0, burst_reg=0, count_reg=0, pre_cnt=0, remain=0, tick_cnt=0.
- Reset outputs: ena_out=0, tick=0, busy=0, done=0, cfg_ready=1.
- Reset mid-operation: block returns to IDLE immediately. No done pulse. Config registers are cleared.
- States: IDLE, RUN, BURST, DONE. cfg_ready = (state==IDLE). busy = (state!=IDLE).
- Config: cfg_valid & cfg_ready latches div_reg, burst_reg and count_reg at the clock edge.
- Config and start in the same IDLE cycle: the new config is latched and that start uses the new values.
- Start, IDLE & start, burst_reg=0 (after any same-cycle config): next state RUN. pre_cnt=0, tick_cnt=0, remain=count_reg.
- Start, IDLE & start, burst_reg=1, count>0: next state BURST, with the same counter initialisation as RUN.
- Start, IDLE & start, burst_reg=1, count=0: next state DONE. No ticks are issued.
- start in any state other than IDLE is ignored.
- ena_out = (state==RUN or state==BURST), registered from state.
- ena_out latency: start sampled at edge k gives ena_out=1 from cycle k+1.
- Prescaler, in RUN/BURST: when pre_cnt==div_reg, tick=1 and pre_cnt wraps to 0; otherwise pre_cnt+1.
- First tick arrives in cycle k+1+div_reg. div_reg=0 gives tick every cycle while running.
- tick is combinational from state and pre_cnt, and is never high outside RUN/BURST.
- Each tick increments tick_cnt by 1. tick_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- tick_cnt holds its value in IDLE until the next start.
- BURST: each tick decrements remain. A tick with remain==1 moves the state to DONE.
- Burst length: exactly count_reg ticks are issued.
- DONE lasts one cycle: done=1, ena_out=0, then the state goes to IDLE.
- stop in RUN/BURST: next state IDLE, with no done pulse.
- stop has priority: a tick due in the same cycle is suppressed and tick_cnt is not incremented.
- stop in IDLE or DONE is ignored.
- div_reg cannot change while running because cfg_ready=0.

Optional Feature:
CLKDIV_CTRL_PAUSE_EN
- Defined: the block adds input pause (1 bit).
- With pause=1 in RUN/BURST: pre_cnt and remain freeze, ena_out=0, tick=0, state is unchanged, busy stays 1.
- stop overrides pause.
- Releasing pause resumes counting from the frozen pre_cnt.
- Not defined: there is no pause port and behaviour is exactly as above.

Test Plan:
- Reset check: assert rst mid-RUN with div=5 -> same cycle outputs ena_out=0, tick=0, busy=0, cfg_ready=1; after release, tick_cnt=0.
- Continuous run: cfg div=3, burst=0, then start at cycle 0 -> ena_out=1 from cycle 1; ticks at cycles 4, 8, 12; after 3 ticks tick_cnt=3.
- Burst: cfg div=0, burst=1, count=5, start -> 5 consecutive ticks at cycles 1-5; done=1 at cycle 6; IDLE with cfg_ready=1 at cycle 7; tick_cnt=5.
- Zero-length burst and same-cycle config: cfg_valid with burst=1, count=0 together with start -> no tick, done pulse one cycle later, then IDLE.
- Stop versus tick: div=2, run, assert stop in the cycle a tick is due -> no tick, tick_cnt unchanged, done=0, IDLE next cycle.
- Handshake and wrap: cfg_valid while RUN -> cfg_ready=0 and div unchanged. With CNT_W=4, run 17 ticks -> tick_cnt=1.

Source files
------------

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl
// Run controller for the clock-divider timebase. Holds a programmable
// divide ratio, enables the divider datapath and emits a one-cycle tick
// every (div+1) clk cycles. It runs either continuously or for a burst of
// N ticks that ends with a one-cycle done pulse. Configuration is offered
// over a valid/ready handshake and is only accepted while idle.
//
// Optional feature macro: CLKDIV_CTRL_PAUSE_EN
//   When defined, adds input 'pause'. While paused in RUN/BURST the
//   prescaler and the burst remainder freeze, ena_out and tick are forced
//   low, and the state is held. stop still wins over pause.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   cfg_valid  configuration offered
//   cfg_ready  configuration can be accepted (IDLE only)
//   cfg_div    divide ratio, tick period = cfg_div+1
//   cfg_burst  0 = continuous run, 1 = burst of cfg_count ticks
//   cfg_count  burst length in ticks
//   start      start request, acted on in IDLE only
//   stop       abort request, acted on in RUN/BURST
//   pause      (CLKDIV_CTRL_PAUSE_EN only) freeze counting
//   ena_out    divider enable, high while running
//   tick       one-cycle pulse at the end of each prescale period
//   busy       high in RUN, BURST or DONE
//   done       one-cycle pulse when a burst completes
//   tick_cnt   ticks issued since the last start, wraps silently

module clkdiv_ctrl #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_burst,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             stop,
`ifdef CLKDIV_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  output logic             ena_out,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [DIV_W-1:0] r_div;
  logic             r_burst;
  logic [CNT_W-1:0] r_count;
  logic [DIV_W-1:0] r_preCnt;
  logic [CNT_W-1:0] r_remain;
  logic [CNT_W-1:0] r_tickCnt;

  logic             w_isIdle;
  logic             w_active;
  logic             w_pause;
  logic             w_cfgFire;
  logic             w_startFire;
  logic             w_effBurst;
  logic [CNT_W-1:0] w_effCount;
  logic             w_tickDue;
  logic             w_tick;
  logic             w_lastTick;
  logic             w_advance;

`ifdef CLKDIV_CTRL_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_isIdle    = (r_state == S_IDLE);
  assign w_active    = (r_state == S_RUN) || (r_state == S_BURST);
  assign w_cfgFire   = cfg_valid && w_isIdle;
  assign w_startFire = start && w_isIdle;

  // A config offered in the same cycle as start must take effect for that
  // start, so the start path looks through to the incoming values.
  assign w_effBurst  = w_cfgFire ? cfg_burst : r_burst;
  assign w_effCount  = w_cfgFire ? cfg_count : r_count;

  // stop and pause both mask a due tick; stop additionally ends the run.
  assign w_tickDue   = w_active && (r_preCnt == r_div);
  assign w_tick      = w_tickDue && !stop && !w_pause;
  assign w_lastTick  = (r_state == S_BURST) && w_tick && (r_remain == CNT_W'(1));
  assign w_advance   = w_active && !stop && !w_pause;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A zero-length burst goes straight to DONE so the
  // caller still gets its completion pulse without any ticks.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!w_effBurst) begin
            w_nextState = S_RUN;
          end else if (w_effCount != '0) begin
            w_nextState = S_BURST;
          end else begin
            w_nextState = S_DONE;
          end
        end
      end
      S_RUN, S_BURST: begin
        if (stop) begin
          w_nextState = S_IDLE;
        end else if (w_lastTick) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Output decode, all derived from the registered state and counters.
  always_comb begin
    cfg_ready = w_isIdle;
    busy      = !w_isIdle;
    ena_out   = w_active && !w_pause;
    tick      = w_tick;
    done      = (r_state == S_DONE);
    tick_cnt  = r_tickCnt;
  end

  // Configuration registers, only writable while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div   <= '0;
      r_burst <= 1'b0;
      r_count <= '0;
    end else if (w_cfgFire) begin
      r_div   <= cfg_div;
      r_burst <= cfg_burst;
      r_count <= cfg_count;
    end
  end

  // Prescaler, tick counter and burst remainder. A start clears the run
  // counters; tick_cnt is otherwise left alone in IDLE so software can read
  // the final count after a stop or a completed burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_preCnt  <= '0;
      r_remain  <= '0;
      r_tickCnt <= '0;
    end else if (w_startFire) begin
      r_preCnt  <= '0;
      r_tickCnt <= '0;
      r_remain  <= w_effCount;
    end else if (w_advance) begin
      if (w_tickDue) begin
        r_preCnt <= '0;
      end else begin
        r_preCnt <= r_preCnt + DIV_W'(1);
      end
      if (w_tick) begin
        r_tickCnt <= r_tickCnt + CNT_W'(1);
      end
      if (w_tick && (r_state == S_BURST)) begin
        r_remain <= r_remain - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl
// Bench for clkdiv_ctrl built with a narrow tick counter (CNT_W=4) so the
// counter wrap is reachable quickly. A directed vector table covers burst,
// zero-length burst with same-cycle config, continuous run, the handshake
// while running and stop versus a due tick; hand-written sequences cover
// async reset mid-run and counter wrap; a randomized phase is checked
// against a cycle-indexed arithmetic model of the run.

module tb_clkdiv_ctrl;

  localparam int DIV_W = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_burst = 1'b0;
  logic [CNT_W-1:0] cfg_count = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             ena_out;
  logic             tick;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] tick_cnt;

  int vecCount = 0;
  int missCount = 0;

  // Expected output vector layout: {ena, tick, busy, done, ready, tick_cnt}
  typedef struct {
    logic             cv;
    logic [DIV_W-1:0] div;
    logic             burst;
    logic [CNT_W-1:0] cnt;
    logic             st;
    logic             sp;
    logic [8:0]       want;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: run progress is tracked as a cycle index since the
  // run began; ticks and the tick count follow from arithmetic on it.
  int         mMode;      // 0 idle, 1 running, 2 done
  int         mRunIdx;
  int         mD;
  int         mLen;
  bit         mIsBurst;
  logic [7:0] mDiv;
  bit         mBurst;
  logic [3:0] mCount;
  logic [3:0] mTc;

  always #5 clk = ~clk;

  clkdiv_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_burst (cfg_burst),
    .cfg_count (cfg_count),
    .start     (start),
    .stop      (stop),
`ifdef CLKDIV_CTRL_PAUSE_EN
    .pause     (1'b0),
`endif
    .ena_out   (ena_out),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .tick_cnt  (tick_cnt)
  );

  function automatic logic [8:0] mkWant(input bit e, input bit t, input bit b,
                                        input bit d, input bit r, input int tc);
    logic [3:0] tc4;
    tc4 = 4'(tc);
    return {e, t, b, d, r, tc4};
  endfunction

  function automatic vec_t mkVec(input bit cv, input int div, input bit burst,
                                 input int cnt, input bit st, input bit sp,
                                 input logic [8:0] want);
    vec_t v;
    v.cv    = cv;
    v.div   = 8'(div);
    v.burst = burst;
    v.cnt   = 4'(cnt);
    v.st    = st;
    v.sp    = sp;
    v.want  = want;
    return v;
  endfunction

  task automatic applyStimulus(input bit cv, input logic [DIV_W-1:0] div,
                               input bit burst, input logic [CNT_W-1:0] cnt,
                               input bit st, input bit sp);
    cfg_valid = cv;
    cfg_div   = div;
    cfg_burst = burst;
    cfg_count = cnt;
    start     = st;
    stop      = sp;
  endtask

  task automatic checkOutput(input string name, input logic [8:0] want);
    logic [8:0] got;
    got = {ena_out, tick, busy, done, cfg_ready, tick_cnt};
    vecCount++;
    if (got !== want) begin
      missCount++;
      $display("[TB] FAIL %s: got ena=%b tick=%b busy=%b done=%b ready=%b cnt=%0d, expected ena=%b tick=%b busy=%b done=%b ready=%b cnt=%0d",
               name, got[8], got[7], got[6], got[5], got[4], got[3:0],
               want[8], want[7], want[6], want[5], want[4], want[3:0]);
    end
  endtask

  // Drive inputs just after a rising edge, compare on the falling edge,
  // then move to just after the next rising edge.
  task automatic stepCheck(input string name, input bit cv, input int div,
                           input bit burst, input int cnt, input bit st,
                           input bit sp, input logic [8:0] want);
    applyStimulus(cv, 8'(div), burst, 4'(cnt), st, sp);
    @(negedge clk);
    checkOutput(name, want);
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    mMode = 0; mRunIdx = 0; mD = 0; mLen = 0; mIsBurst = 0;
    mDiv = '0; mBurst = 0; mCount = '0; mTc = '0;
  endtask

  function automatic logic [8:0] modelExpect(input bit sp);
    bit running;
    bit due;
    int tcNow;
    running = (mMode == 1);
    due     = running && ((mRunIdx % (mD + 1)) == mD);
    tcNow   = running ? ((mRunIdx / (mD + 1)) % 16) : int'(mTc);
    return mkWant(running, due && !sp, mMode != 0, mMode == 2, mMode == 0, tcNow);
  endfunction

  task automatic modelStep(input bit cv, input logic [7:0] div, input bit burst,
                           input logic [3:0] cnt, input bit st, input bit sp);
    bit due;
    case (mMode)
      0: begin
        if (cv) begin
          mDiv = div; mBurst = burst; mCount = cnt;
        end
        if (st) begin
          if (mBurst && mCount == 0) begin
            mMode = 2;
            mTc   = '0;
          end else begin
            mMode    = 1;
            mRunIdx  = 0;
            mD       = int'(mDiv);
            mIsBurst = mBurst;
            mLen     = int'(mCount);
          end
        end
      end
      1: begin
        due = ((mRunIdx % (mD + 1)) == mD);
        if (sp) begin
          mMode = 0;
          mTc   = 4'((mRunIdx / (mD + 1)) % 16);
        end else if (mIsBurst && due && (mRunIdx + 1 == mLen * (mD + 1))) begin
          mMode = 2;
          mTc   = 4'(mLen % 16);
        end else begin
          mRunIdx++;
        end
      end
      default: mMode = 0;
    endcase
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    applyStimulus(0, '0, 0, '0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Directed table: one row per clock cycle.
    tbl.push_back(mkVec(1, 0, 1, 5, 1, 0, mkWant(0, 0, 0, 0, 1, 0)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(1, 1, 1, 0, 0, 0)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(1, 1, 1, 0, 0, 1)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(1, 1, 1, 0, 0, 2)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(1, 1, 1, 0, 0, 3)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(1, 1, 1, 0, 0, 4)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(0, 0, 1, 1, 0, 5)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(0, 0, 0, 0, 1, 5)));
    tbl.push_back(mkVec(1, 0, 1, 0, 1, 0, mkWant(0, 0, 0, 0, 1, 5)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(0, 0, 1, 1, 0, 0)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(0, 0, 0, 0, 1, 0)));
    tbl.push_back(mkVec(1, 3, 0, 0, 1, 0, mkWant(0, 0, 0, 0, 1, 0)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(1, 0, 1, 0, 0, 0)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(1, 0, 1, 0, 0, 0)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(1, 0, 1, 0, 0, 0)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(1, 1, 1, 0, 0, 0)));
    tbl.push_back(mkVec(1, 7, 0, 0, 0, 0, mkWant(1, 0, 1, 0, 0, 1)));
    tbl.push_back(mkVec(0, 0, 0, 0, 1, 0, mkWant(1, 0, 1, 0, 0, 1)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(1, 0, 1, 0, 0, 1)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(1, 1, 1, 0, 0, 1)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(1, 0, 1, 0, 0, 2)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(1, 0, 1, 0, 0, 2)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(1, 0, 1, 0, 0, 2)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 1, mkWant(1, 0, 1, 0, 0, 2)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, mkWant(0, 0, 0, 0, 1, 2)));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 1, mkWant(0, 0, 0, 0, 1, 2)));

    // Reset state.
    #1;
    @(negedge clk);
    checkOutput("reset_state", mkWant(0, 0, 0, 0, 1, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      stepCheck($sformatf("table_row%0d", i), tbl[i].cv, int'(tbl[i].div),
                tbl[i].burst, int'(tbl[i].cnt), tbl[i].st, tbl[i].sp, tbl[i].want);
    end

    // Async reset in the middle of a run with div=5.
    stepCheck("rst_cfg_start", 1, 5, 0, 0, 1, 0, mkWant(0, 0, 0, 0, 1, 2));
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, '0, 0, '0, 0, 0);
      @(posedge clk);
      #1;
    end
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_midrun_async", mkWant(0, 0, 0, 0, 1, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    stepCheck("rst_after_release", 0, 0, 0, 0, 0, 0, mkWant(0, 0, 0, 0, 1, 0));
    // Config was cleared by reset, so a bare start runs with div=0.
    stepCheck("rst_start_nocfg", 0, 0, 0, 0, 1, 0, mkWant(0, 0, 0, 0, 1, 0));
    stepCheck("rst_div_cleared", 0, 0, 0, 0, 0, 0, mkWant(1, 1, 1, 0, 0, 0));
    stepCheck("rst_stop", 0, 0, 0, 0, 0, 1, mkWant(1, 0, 1, 0, 0, 1));

    // Tick counter wrap: 17 ticks in a 4-bit counter leave 1.
    stepCheck("wrap_start", 1, 0, 0, 0, 1, 0, mkWant(0, 0, 0, 0, 1, 1));
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, '0, 0, '0, 0, 0);
      @(posedge clk);
      #1;
    end
    stepCheck("wrap_tick17", 0, 0, 0, 0, 0, 0, mkWant(1, 1, 1, 0, 0, 0));
    stepCheck("wrap_stop", 0, 0, 0, 0, 0, 1, mkWant(1, 0, 1, 0, 0, 1));
    stepCheck("wrap_hold_idle", 0, 0, 0, 0, 0, 0, mkWant(0, 0, 0, 0, 1, 1));

    // Randomized traffic against the model.
    pulseReset();
    modelReset();
    for (int i = 0; i < 3000; i++) begin
      bit         rcv;
      bit         rb;
      bit         rst_;
      bit         rsp;
      logic [7:0] rdiv;
      logic [3:0] rcnt;
      rcv  = ($urandom_range(0, 99) < 30);
      rdiv = 8'($urandom_range(0, 3));
      rb   = $urandom_range(0, 1) == 1;
      rcnt = 4'($urandom_range(0, 6));
      rst_ = ($urandom_range(0, 99) < 20);
      rsp  = ($urandom_range(0, 99) < 4);
      stepCheck($sformatf("random_cycle%0d", i), rcv, int'(rdiv), rb, int'(rcnt),
                rst_, rsp, modelExpect(rsp));
      modelStep(rcv, rdiv, rb, rcnt, rst_, rsp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
